// File: rtl/alsu_pipe.sv
// Handshaked arithmetic/logic/shift unit with a bit-serial shift/rotate engine.
// Operands are WIDTH-bit signed; the result register is 2*WIDTH bits wide.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; inputs are captured on in_valid
// EXEC  | computing: single-cycle result, or shifting 1 bit per clock
// DONE  | result held on out until the consumer takes it
module alsu_pipe #(
  parameter int WIDTH          = 4,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [WIDTH-1:0]         A,
  input  logic signed [WIDTH-1:0]         B,
  input  logic                            cin,
  input  logic [2:0]                      opcode,
  input  logic                            red_op_A,
  input  logic                            red_op_B,
  input  logic                            bypass_A,
  input  logic                            bypass_B,
  input  logic                            direction,
  input  logic                            serial_in,
  input  logic [$clog2(2*WIDTH)-1:0]      sh_amt,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [2*WIDTH-1:0]       out,
  output logic [LED_W-1:0]                leds
);

  localparam int OUT_W  = 2 * WIDTH;
  localparam int SH_W   = $clog2(OUT_W);
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [SH_W-1:0]         cnt;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic                    cin_q, ra_q, rb_q, ba_q, bb_q, dir_q, si_q;
  logic [2:0]              op_q;

  logic                    accept;
  logic                    load_shift;
  logic                    invalid_c, bypass_c, show_inv;
  logic [OUT_W-1:0]        a_ext, b_ext, cin_ext, bw_ext;
  logic [WIDTH-1:0]        bw, red_src;
  logic                    rbit, fill_l, fill_r;
  logic [OUT_W-1:0]        result_c, shift_c;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid;

  // A shift/rotate only runs serially when nothing overrides it: any bypass
  // wins, and any reduction flag makes opcodes 4/5 invalid.
  assign load_shift = (opcode == 3'd4 || opcode == 3'd5) &&
                      !(bypass_A || bypass_B) && !(red_op_A || red_op_B);

  assign invalid_c = ((ra_q || rb_q) && (op_q[2:1] != 2'b00)) || (op_q[2:1] == 2'b11);
  assign bypass_c  = ba_q || bb_q;
  assign show_inv  = invalid_c && !bypass_c;

  assign a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign cin_ext = {{(OUT_W-1){1'b0}}, cin_q & FA_ON};
  assign bw      = op_q[0] ? (a_q ^ b_q) : (a_q | b_q);
  assign bw_ext  = {{WIDTH{bw[WIDTH-1]}}, bw};
  assign red_src = (ra_q && rb_q) ? (PRIO_A ? a_q : b_q) : (ra_q ? a_q : b_q);
  assign rbit    = op_q[0] ? ^red_src : |red_src;

  // Rotate (opcode 5) recirculates the outgoing bit; shift (4) takes serial_in.
  assign fill_l  = op_q[0] ? out[OUT_W-1] : si_q;
  assign fill_r  = op_q[0] ? out[0] : si_q;
  assign shift_c = dir_q ? {out[OUT_W-2:0], fill_l} : {fill_r, out[OUT_W-1:1]};

  // Result selection in priority order: dual bypass, bypass A, bypass B, invalid, opcode.
  always_comb begin
    result_c = '0;
    if (ba_q && bb_q)      result_c = PRIO_A ? a_ext : b_ext;
    else if (ba_q)         result_c = a_ext;
    else if (bb_q)         result_c = b_ext;
    else if (invalid_c)    result_c = '0;
    else begin
      case (op_q)
        3'd0, 3'd1: result_c = (ra_q || rb_q) ? {{(OUT_W-1){1'b0}}, rbit} : bw_ext;
        3'd2:       result_c = a_ext + b_ext + cin_ext;
        3'd3:       result_c = a_ext * b_ext;
        3'd4, 3'd5: result_c = out;
        default:    result_c = '0;
      endcase
    end
  end

  // Request capture; these registers stay stable for the whole operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      op_q  <= '0;
      ra_q  <= 1'b0;
      rb_q  <= 1'b0;
      ba_q  <= 1'b0;
      bb_q  <= 1'b0;
      dir_q <= 1'b0;
      si_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= cin;
      op_q  <= opcode;
      ra_q  <= red_op_A;
      rb_q  <= red_op_B;
      ba_q  <= bypass_A;
      bb_q  <= bypass_B;
      dir_q <= direction;
      si_q  <= serial_in;
    end
  end

  // Control FSM with shift down-counter, result register and invalid indicator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      leds  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= load_shift ? sh_amt : '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            out   <= result_c;
            leds  <= show_inv ? '1 : '0;
            state <= DONE;
          end else begin
            out <= shift_c;
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            leds  <= '0;
          end else if (show_inv) begin
            leds <= ~leds;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe (WIDTH=4). Two instances differ only in
// INPUT_PRIORITY so both priority choices are exercised on the same stimulus.
module tb_alsu_pipe;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [3:0] A = '0, B = '0;
  logic              cin = 1'b0;
  logic [2:0]        opcode = '0;
  logic              red_op_A = 1'b0, red_op_B = 1'b0;
  logic              bypass_A = 1'b0, bypass_B = 1'b0;
  logic              direction = 1'b0, serial_in = 1'b0;
  logic [2:0]        sh_amt = '0;
  logic              out_ready = 1'b0;

  logic              in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [7:0]        out_a, out_b;
  logic [15:0]       leds_a, leds_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_a = '0, exp_b = '0;
  int         exp_lat;
  bit         exp_inv;

  always #5 clk = ~clk;

  alsu_pipe #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .A(A), .B(B), .cin(cin), .opcode(opcode),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .direction(direction), .serial_in(serial_in), .sh_amt(sh_amt),
    .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .leds(leds_a));

  alsu_pipe #(.WIDTH(4), .INPUT_PRIORITY("B"), .FULL_ADDER("ON"), .LED_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .A(A), .B(B), .cin(cin), .opcode(opcode),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .direction(direction), .serial_in(serial_in), .sh_amt(sh_amt),
    .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .leds(leds_b));

  // Reference model: operands as plain signed integers, shifts as *2 and /2 on 0..255.
  function automatic logic [7:0] model(input bit prio_b, input logic [7:0] prev,
                                       input int a, input int b, input int c, input int op,
                                       input bit ra, input bit rb, input bit ba, input bit bb,
                                       input bit dir, input bit si, input int amt);
    int v, s, ones, ua, ub, bw, bit_out;
    v = 0;
    if (ba && bb)                         v = prio_b ? b : a;
    else if (ba)                          v = a;
    else if (bb)                          v = b;
    else if (op >= 6 || ((ra || rb) && op >= 2)) v = 0;
    else if (op <= 1) begin
      if (ra || rb) begin
        s = (ra && rb) ? (prio_b ? b : a) : (ra ? a : b);
        ones = 0;
        for (int i = 0; i < 4; i++) ones += (s >> i) & 1;
        v = (op == 0) ? int'(ones > 0) : ones % 2;
      end else begin
        ua = a & 15;
        ub = b & 15;
        bw = (op == 0) ? (ua | ub) : (ua ^ ub);
        v = (bw >= 8) ? bw - 16 : bw;
      end
    end
    else if (op == 2) v = a + b + c;
    else if (op == 3) v = a * b;
    else begin
      v = int'(prev);
      for (int k = 0; k < amt; k++) begin
        if (dir) begin
          bit_out = v / 128;
          v = (v * 2) % 256 + ((op == 5) ? bit_out : int'(si));
        end else begin
          bit_out = v % 2;
          v = v / 2 + 128 * ((op == 5) ? bit_out : int'(si));
        end
      end
    end
    return v[7:0];
  endfunction

  // Issue one request, update predictions, and return cycles from accept to out_valid.
  task automatic send(input int a, input int b, input int c, input int op,
                      input bit ra, input bit rb, input bit ba, input bit bb,
                      input bit dir, input bit si, input int amt, output int lat);
    int w;
    w = 0;
    while (!in_ready_a && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    exp_a   = model(1'b0, exp_a, a, b, c, op, ra, rb, ba, bb, dir, si, amt);
    exp_b   = model(1'b1, exp_b, a, b, c, op, ra, rb, ba, bb, dir, si, amt);
    exp_inv = !(ba || bb) && (op >= 6 || ((ra || rb) && op >= 2));
    exp_lat = 1 + (((op == 4 || op == 5) && !ba && !bb && !ra && !rb) ? amt : 0);
    @(negedge clk);
    A = a[3:0]; B = b[3:0]; cin = c[0]; opcode = op[2:0];
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
    direction = dir; serial_in = si; sh_amt = amt[2:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid_a) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_a !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", out_a); end
    n_cmp++; if (leds_a !== 16'h0) begin n_err++; $display("FAIL reset_leds: got %h want 0000", leds_a); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
  endtask

  task automatic test_add();
    int lat;
    send(-3, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d want 1", lat); end
    n_cmp++; if (out_a !== 8'h03) begin n_err++; $display("FAIL add_out: got %h want 03", out_a); end
    n_cmp++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL add_in_ready: got %b want 0", in_ready_a); end
    consume();
    n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL add_consume: got in_ready %b want 1", in_ready_a); end
  endtask

  task automatic test_mul_backpressure();
    int lat;
    send(-8, 7, 0, 3, 0, 0, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (out_a !== 8'hC8) begin n_err++; $display("FAIL mul_out: got %h want c8", out_a); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        A = 4'sd1; B = 4'sd1; opcode = 3'd2; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_cmp++; if (out_a !== 8'hC8 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
        n_err++; $display("FAIL mul_hold[%0d]: got out=%h v=%b r=%b want c8 1 0", i, out_a, out_valid_a, in_ready_a);
      end
    end
    in_valid = 1'b0;
    consume();
    n_cmp++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      n_err++; $display("FAIL mul_release: got r=%b v=%b want 1 0", in_ready_a, out_valid_a);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL mul_ignored_req: got out_valid %b want 0", out_valid_a); end
  endtask

  task automatic test_shift_rotate();
    int lat;
    send(1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, lat); consume();
    send(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, lat);
    n_cmp++; if (out_a !== 8'h81) begin n_err++; $display("FAIL rot_prep: got %h want 81", out_a); end
    consume();
    send(0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 3, lat);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL shift_latency: got %0d want 4", lat); end
    n_cmp++; if (out_a !== 8'h08) begin n_err++; $display("FAIL shift_out: got %h want 08", out_a); end
    consume();
    send(1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, lat); consume();
    send(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, lat); consume();
    send(0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 3, lat);
    n_cmp++; if (lat !== 4 || out_a !== 8'h0C) begin
      n_err++; $display("FAIL rotate_out: got lat=%0d out=%h want 4 0c", lat, out_a);
    end
    consume();
    send(0, 0, 0, 4, 0, 0, 0, 0, 1, 1, 0, lat);
    n_cmp++; if (lat !== 1 || out_a !== 8'h0C) begin
      n_err++; $display("FAIL shift_zero: got lat=%0d out=%h want 1 0c", lat, out_a);
    end
    consume();
    send(0, 0, 0, 4, 0, 0, 0, 0, 0, 1, 5, lat);
    n_cmp++; if (lat !== exp_lat || out_a !== exp_a) begin
      n_err++; $display("FAIL shift_right_fill: got lat=%0d out=%h want %0d %h", lat, out_a, exp_lat, exp_a);
    end
    consume();
  endtask

  task automatic test_invalid_bypass();
    int lat;
    send(3, 2, 0, 6, 0, 0, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (out_a !== 8'h00 || leds_a !== 16'hFFFF) begin
      n_err++; $display("FAIL inv6_first: got out=%h leds=%h want 00 ffff", out_a, leds_a);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (leds_a !== ((k % 2) ? 16'h0000 : 16'hFFFF)) begin
        n_err++; $display("FAIL inv6_toggle[%0d]: got %h", k, leds_a);
      end
    end
    consume();
    n_cmp++; if (leds_a !== 16'h0) begin n_err++; $display("FAIL inv6_clear: got %h want 0000", leds_a); end
    send(3, 2, 0, 2, 1, 0, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (out_a !== 8'h00 || leds_a !== 16'hFFFF) begin
      n_err++; $display("FAIL inv_red_add: got out=%h leds=%h want 00 ffff", out_a, leds_a);
    end
    @(posedge clk); #1;
    n_cmp++; if (leds_a !== 16'h0000) begin n_err++; $display("FAIL inv_red_toggle: got %h want 0000", leds_a); end
    consume();
    send(-6, 5, 0, 7, 0, 0, 1, 1, 0, 0, 0, lat);
    n_cmp++; if (out_a !== 8'hFA || leds_a !== 16'h0) begin
      n_err++; $display("FAIL bypass_both_a: got out=%h leds=%h want fa 0000", out_a, leds_a);
    end
    n_cmp++; if (out_b !== 8'h05) begin n_err++; $display("FAIL bypass_both_b: got %h want 05", out_b); end
    consume();
  endtask

  task automatic test_reduction();
    int lat;
    send(7, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (out_b !== 8'h01) begin n_err++; $display("FAIL reduce_xor_b: got %h want 01", out_b); end
    consume();
    send(0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (out_a !== 8'h00) begin n_err++; $display("FAIL reduce_or_a: got %h want 00", out_a); end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    send(1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, lat); consume();
    @(negedge clk);
    opcode = 3'd4; direction = 1'b1; serial_in = 1'b1; sh_amt = 3'd7;
    red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (out_a !== 8'h00 || leds_a !== 16'h0 || out_valid_a !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: got out=%h leds=%h v=%b want 00 0000 0", out_a, leds_a, out_valid_a);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_a = '0; exp_b = '0;
    #1;
    n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready: got %b want 1", in_ready_a); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_result: got %b want 0", out_valid_a); end
    send(4, -2, 1, 2, 0, 0, 0, 0, 0, 0, 0, lat);
    n_cmp++; if (lat !== 1 || out_a !== 8'h03) begin
      n_err++; $display("FAIL reset_mid_add: got lat=%0d out=%h want 1 03", lat, out_a);
    end
    consume();
  endtask

  task automatic test_random();
    int lat, op, amt;
    bit ra, rb, ba, bb;
    for (int it = 0; it < 60; it++) begin
      op  = $urandom_range(0, 7);
      ra  = ($urandom_range(0, 3) == 0);
      rb  = ($urandom_range(0, 3) == 0);
      ba  = ($urandom_range(0, 5) == 0);
      bb  = ($urandom_range(0, 5) == 0);
      amt = $urandom_range(0, 7);
      send(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
           $urandom_range(0, 1), op, ra, rb, ba, bb,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), amt, lat);
      n_cmp++; if (lat !== exp_lat) begin
        n_err++; $display("FAIL rand_lat[%0d] op=%0d: got %0d want %0d", it, op, lat, exp_lat);
      end
      n_cmp++; if (out_a !== exp_a || out_b !== exp_b) begin
        n_err++; $display("FAIL rand_out[%0d] op=%0d: got %h/%h want %h/%h", it, op, out_a, out_b, exp_a, exp_b);
      end
      n_cmp++; if (leds_a !== (exp_inv ? 16'hFFFF : 16'h0000)) begin
        n_err++; $display("FAIL rand_leds[%0d]: got %h want inv=%b", it, leds_a, exp_inv);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      n_cmp++; if (out_a !== exp_a || out_valid_a !== 1'b1) begin
        n_err++; $display("FAIL rand_hold[%0d]: got out=%h v=%b want %h 1", it, out_a, out_valid_a, exp_a);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_backpressure();
    test_shift_rotate();
    test_invalid_bypass();
    test_reduction();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
